// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch path and the
// data load/store path. One access at a time: grant, hold the memory interface
// stable for LATENCY cycles, capture read data, then pulse the owner's ack.
// Ties go round-robin so neither requester can starve the other.
module mem_port_arbiter #(
  parameter int LATENCY = 2,  // 1..15
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            owner;       // 1 = data path owns the access in flight
  logic            last_grant;  // 1 = data path was served last
  logic            grant_dm;    // requester chosen if a grant happens this cycle
  logic [AW-1:0]   lat_addr;
  logic            lat_we;
  logic [DW-1:0]   lat_wdata;
  logic [3:0]      cnt;

  // Pick the winner: a lone requester wins, a tie goes to whoever was not served last.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant_dm = dm_req;
    if (if_req && dm_req) grant_dm = ~last_grant;
  end

  // Next-state decode; req inputs only matter in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (if_req || dm_req) state_next = ACCESS;
      ACCESS:  if (cnt == 4'd0)      state_next = RESP;
      RESP:                          state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // State register; reset abandons any access in flight without an ack.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Grant latch, latency countdown and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      cnt        <= 4'd0;
      rdata      <= '0;
    end else begin
      if (state == IDLE && state_next == ACCESS) begin
        owner      <= grant_dm;
        last_grant <= grant_dm;
        lat_addr   <= grant_dm ? dm_addr : if_addr;
        lat_we     <= grant_dm & dm_we;  // fetches are always reads
        lat_wdata  <= grant_dm ? dm_wdata : '0;
        cnt        <= 4'(LATENCY - 1);
      end else if (state == ACCESS) begin
        if (cnt != 4'd0)  cnt   <= cnt - 4'd1;
        else if (!lat_we) rdata <= mem_rdata;  // stores leave rdata alone
      end
    end
  end

  // Outputs decode from state and latched registers only, never from req inputs.
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign busy      = (state != IDLE);
  assign if_ack    = (state == RESP) & ~owner;
  assign dm_ack    = (state == RESP) & owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset values, a table of single
// accesses, async reset mid-access, tie-break / round-robin, and LATENCY=1.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_ack, dm_ack, busy, mem_en, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata;

  logic        dm_req_1, dm_we_1;
  logic [15:0] dm_addr_1, dm_wdata_1, mem_rdata_1;
  logic        if_ack_1, dm_ack_1, busy_1, mem_en_1, mem_we_1;
  logic [15:0] rdata_1, mem_addr_1, mem_wdata_1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(2), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.LATENCY(1), .AW(16), .DW(16)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(16'h0000), .if_ack(if_ack_1),
    .dm_req(dm_req_1), .dm_we(dm_we_1), .dm_addr(dm_addr_1), .dm_wdata(dm_wdata_1),
    .dm_ack(dm_ack_1), .rdata(rdata_1), .busy(busy_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
  );

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mem_data;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    dm_req_1 = 1'b0; dm_we_1 = 1'b0; dm_addr_1 = '0; dm_wdata_1 = '0; mem_rdata_1 = '0;

    //                 is_dm  we    addr      wdata     mem_data  exp_rdata
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hABCD, 16'hABCD};
    vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 16'hEEEE, 16'hABCD};
    vecs[2] = '{1'b1, 1'b0, 16'h0300, 16'h9999, 16'h7777, 16'h7777};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001};
    vecs[4] = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h1111, 16'h0001};

    tick();
    tick();
    // Reset values
    check_bit ("rst if_ack",    if_ack,    1'b0);
    check_bit ("rst dm_ack",    dm_ack,    1'b0);
    check_bit ("rst busy",      busy,      1'b0);
    check_bit ("rst mem_en",    mem_en,    1'b0);
    check_bit ("rst mem_we",    mem_we,    1'b0);
    check_word("rst mem_addr",  mem_addr,  16'h0000);
    check_word("rst mem_wdata", mem_wdata, 16'h0000);
    check_word("rst rdata",     rdata,     16'h0000);
    rst = 1'b0;

    // Table of single accesses, LATENCY=2: ACCESS cycles 1-2, ack at cycle 3.
    for (int i = 0; i < 5; i++) begin
      mem_rdata = vecs[i].mem_data;
      if (vecs[i].is_dm) begin
        dm_req = 1'b1; dm_we = vecs[i].we; dm_addr = vecs[i].addr; dm_wdata = vecs[i].wdata;
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr;
      end
      for (int c = 1; c <= 2; c++) begin
        tick();
        // Disturb the owner's inputs after grant; the access must not notice.
        dm_we = ~dm_we; dm_addr = ~dm_addr; dm_wdata = ~dm_wdata; if_addr = ~if_addr;
        check_bit ($sformatf("v%0d c%0d mem_en", i, c),   mem_en,   1'b1);
        check_bit ($sformatf("v%0d c%0d busy", i, c),     busy,     1'b1);
        check_bit ($sformatf("v%0d c%0d mem_we", i, c),   mem_we,   vecs[i].is_dm & vecs[i].we);
        check_word($sformatf("v%0d c%0d mem_addr", i, c), mem_addr, vecs[i].addr);
        if (vecs[i].is_dm && vecs[i].we)
          check_word($sformatf("v%0d c%0d mem_wdata", i, c), mem_wdata, vecs[i].wdata);
        check_bit ($sformatf("v%0d c%0d if_ack", i, c),   if_ack,   1'b0);
        check_bit ($sformatf("v%0d c%0d dm_ack", i, c),   dm_ack,   1'b0);
      end
      tick();
      check_bit ($sformatf("v%0d c3 if_ack", i), if_ack, ~vecs[i].is_dm);
      check_bit ($sformatf("v%0d c3 dm_ack", i), dm_ack, vecs[i].is_dm);
      check_bit ($sformatf("v%0d c3 mem_en", i), mem_en, 1'b0);
      check_bit ($sformatf("v%0d c3 busy", i),   busy,   1'b1);
      check_word($sformatf("v%0d c3 rdata", i),  rdata,  vecs[i].exp_rdata);
      if_req = 1'b0; dm_req = 1'b0;
      tick();
      check_bit ($sformatf("v%0d c4 busy", i),   busy,   1'b0);
      check_bit ($sformatf("v%0d c4 dm_ack", i), dm_ack, 1'b0);
      check_bit ($sformatf("v%0d c4 if_ack", i), if_ack, 1'b0);
    end

    // Async reset during cycle 2 of a data load to 0x0300.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0300; mem_rdata = 16'h5A5A;
    tick();
    tick();
    check_bit("ar c2 mem_en before rst", mem_en, 1'b1);
    rst = 1'b1;
    #1;
    check_bit ("ar mem_en",   mem_en,   1'b0);
    check_bit ("ar busy",     busy,     1'b0);
    check_bit ("ar dm_ack",   dm_ack,   1'b0);
    check_word("ar mem_addr", mem_addr, 16'h0000);
    check_word("ar rdata",    rdata,    16'h0000);
    tick();
    check_bit("ar held dm_ack", dm_ack, 1'b0);
    rst = 1'b0;
    tick();
    check_bit ("ar re c1 mem_en",   mem_en,   1'b1);
    check_word("ar re c1 mem_addr", mem_addr, 16'h0300);
    tick();
    check_bit ("ar re c2 mem_en",   mem_en,   1'b1);
    check_bit ("ar re c2 dm_ack",   dm_ack,   1'b0);
    tick();
    check_bit ("ar re c3 dm_ack",   dm_ack,   1'b1);
    check_word("ar re c3 rdata",    rdata,    16'h5A5A);
    dm_req = 1'b0;
    tick();

    // Tie right after reset, both requests held: dm, if, dm, if every 4 cycles.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0080; mem_rdata = 16'hC0DE;
    for (int c = 1; c <= 16; c++) begin
      tick();
      check_bit($sformatf("rr c%0d dm_ack", c), dm_ack, (c == 3) || (c == 11));
      check_bit($sformatf("rr c%0d if_ack", c), if_ack, (c == 7) || (c == 15));
      check_bit($sformatf("rr c%0d mem_en", c), mem_en, (c % 4 == 1) || (c % 4 == 2));
      if (c % 4 == 1 || c % 4 == 2)
        check_word($sformatf("rr c%0d mem_addr", c), mem_addr,
                   ((c / 4) % 2 == 0) ? 16'h0080 : 16'h0040);
      check_bit($sformatf("rr c%0d ack overlap", c), if_ack & dm_ack, 1'b0);
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    tick();

    // LATENCY=1 instance: load 0x0004 -> mem_en cycle 1 only, ack + rdata cycle 2.
    dm_req_1 = 1'b1; dm_we_1 = 1'b0; dm_addr_1 = 16'h0004; mem_rdata_1 = 16'h00FF;
    tick();
    check_bit ("l1 c1 mem_en",   mem_en_1,   1'b1);
    check_word("l1 c1 mem_addr", mem_addr_1, 16'h0004);
    check_bit ("l1 c1 dm_ack",   dm_ack_1,   1'b0);
    tick();
    check_bit ("l1 c2 mem_en",   mem_en_1,   1'b0);
    check_bit ("l1 c2 dm_ack",   dm_ack_1,   1'b1);
    check_bit ("l1 c2 if_ack",   if_ack_1,   1'b0);
    check_word("l1 c2 rdata",    rdata_1,    16'h00FF);
    dm_req_1 = 1'b0;
    tick();
    check_bit ("l1 c3 busy",     busy_1,     1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares a single-port 16-bit memory between the instruction-fetch path and the data load/store path of the multicycle processor. Each requester raises a request, the arbiter grants one at a time, drives the memory for a fixed access latency, captures read data and returns a one-cycle acknowledge. Ties are resolved round-robin so that neither fetch nor data access can starve.

## Interface

Parameters:
- LATENCY, 2: memory cycles per access (read data valid after LATENCY cycles of stable mem_en/addr); legal range 1..15
- AW, 16: address width
- DW, 16: data width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle pulse: fetch complete, rdata valid
- dm_req  in  1  data request; held high until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_ack  out  1  one-cycle pulse: data access complete
- rdata  out  DW  captured read data, shared by both requesters, qualified by the ack
- busy  out  1  high in ACCESS and RESP
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

## Operation

- States: IDLE, ACCESS, RESP.
- IDLE: no request -> stay. Exactly one req high -> grant it. Both high -> grant the requester not served last (last_grant register; reset value = fetch, so first tie goes to data).
- On grant (IDLE->ACCESS edge): latch owner, address, we (fetch forces we=0), wdata; load cnt = LATENCY-1; update last_grant.
- ACCESS: mem_en=1, mem_we/mem_addr/mem_wdata driven from latched values, stable every ACCESS cycle. cnt decrements each cycle; at cnt=0, capture mem_rdata into rdata (loads and fetches only; stores leave rdata unchanged), go to RESP.
- RESP: owner's ack=1 for exactly one cycle; mem_en=0; req inputs ignored; -> IDLE.
- Requester may keep req high during its ack cycle; it must drop req the following cycle or it is treated as a new request.
- Input changes on the granted requester after grant have no effect on the access in flight.
- if_ack and dm_ack never high together; no ack outside RESP.
- Reset (any time, including mid-ACCESS): state=IDLE, access abandoned with no ack, last_grant=fetch.
- Reset values: if_ack=0, dm_ack=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0.

## Timing

- Request sampled high in IDLE at cycle N -> ACCESS cycles N+1..N+LATENCY -> ack at cycle N+LATENCY+1.
- mem_rdata sampled at the rising edge ending cycle N+LATENCY; rdata valid from N+LATENCY+1 and held until next load/fetch capture.
- RESP always returns to IDLE: one idle bubble; back-to-back accesses issue every LATENCY+2 cycles.
- All outputs registered or decoded from state/latched registers only; no combinational path from req inputs to mem_* or acks.
- busy high N+1..N+LATENCY+1.

## Test plan

- Single fetch, LATENCY=2: if_req at cycle 0, if_addr=0x0010, memory returns 0xABCD -> mem_en high cycles 1-2 with mem_addr=0x0010, mem_we=0; if_ack and rdata=0xABCD at cycle 3.
- Data store: dm_req, dm_we=1, dm_addr=0x0200, dm_wdata=0x1234 -> mem_we=1, mem_addr=0x0200, mem_wdata=0x1234 stable cycles 1-2; dm_ack cycle 3; rdata unchanged.
- Simultaneous if_req and dm_req right after reset -> dm served first (dm_ack cycle 3), fetch granted cycle 4, if_ack cycle 7.
- Both requests held continuously (re-raised after each ack) for 4 accesses -> ack order dm, if, dm, if, one every 4 cycles; never both acks in one cycle.
- rst pulsed during cycle 2 of a dm load to 0x0300 -> all outputs 0 immediately, no dm_ack; after release dm_req still high gets a fresh access with full LATENCY.
- LATENCY=1 build, dm load 0x0004 returning 0x00FF -> mem_en only cycle 1, dm_ack and rdata=0x00FF at cycle 2.
